// File: rtl/led7seg_scan.sv
// Multiplexed common-anode 7-segment scanner: double-buffered digit patterns,
// per-slot dead time, frame-aligned updates so a new value never tears mid-frame.
module led7seg_scan #(
  parameter int NDIG       = 4,
  parameter int DIV        = 100000,
  parameter int BLANK      = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8*NDIG-1:0] seg_in,
  input  logic              load,
  output logic [NDIG-1:0]   an,
  output logic [7:0]        cath,
  output logic              frame,
  output logic              pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};
  localparam logic [7:0]      CATH_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [8*NDIG-1:0] shadow, shadow_nxt;
  logic [8*NDIG-1:0] disp, disp_nxt;
  logic              pending_nxt;
  logic              last_cnt, boundary, blank;
  logic [NDIG-1:0]   an_act;
  logic [7:0]        cath_act;

  // Stage p0: scan position and the shadow/display buffer handoff
  always_comb begin
    last_cnt    = (cnt == CNT_LAST);
    boundary    = last_cnt && (idx == IDX_LAST);
    cnt_nxt     = last_cnt ? '0 : cnt + CW'(1);
    idx_nxt     = idx;
    if (last_cnt) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
    disp_nxt    = disp;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    if (boundary) begin
      // A load landing exactly on the boundary bypasses the shadow wait.
      if (load) begin
        disp_nxt   = seg_in;
        shadow_nxt = seg_in;
      end else if (pending) begin
        disp_nxt = shadow;
      end
      pending_nxt = 1'b0;
    end else if (load) begin
      shadow_nxt  = seg_in;
      pending_nxt = 1'b1;
    end

    // Drivers are computed for the position the counter moves to, so dead
    // time lines up with the first BLANK cycles of every slot.
    blank    = int'({1'b0, cnt_nxt}) < BLANK;
    an_act   = '0;
    cath_act = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_nxt == IW'(k)) begin
        an_act[k] = 1'b1;
        cath_act  = disp_nxt[8*k +: 8];
      end
    end
    if (blank) begin
      an_act   = '0;
      cath_act = '0;
    end
  end

  // Stage p1: registered pin drivers and frame strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      frame   <= 1'b0;
      an      <= AN_OFF;
      cath    <= CATH_OFF;
    end else begin
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shadow  <= shadow_nxt;
      disp    <= disp_nxt;
      pending <= pending_nxt;
      frame   <= boundary;
      an      <= an_act ^ AN_OFF;
      cath    <= cath_act ^ CATH_OFF;
    end
  end

endmodule

// File: tb/tb_led7seg_scan.sv
// Directed bench for led7seg_scan with NDIG=4, DIV=8, BLANK=2, active-low pins.
module tb_led7seg_scan;

  logic        clk;
  logic        rst;
  logic [31:0] seg_in;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  cath;
  logic        frame;
  logic        pending;

  int vectors;
  int miscompares;
  int k;

  led7seg_scan #(.NDIG(4), .DIV(8), .BLANK(2), .ACTIVE_LOW(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .load    (load),
    .an      (an),
    .cath    (cath),
    .frame   (frame),
    .pending (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k counts rising edges since the last reset release; sampling is on negedge.
  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic go_to(input int target);
    while (k < target) step();
  endtask

  // Scan from the current cycle to the next frame start, checking every cycle.
  task automatic test_scan_frame(input logic [31:0] d, input logic exp_pend, input string tag);
    int c, dg;
    logic [3:0] exp_an;
    logic [7:0] exp_cath;
    logic exp_frame;
    do begin
      c  = k % 8;
      dg = (k / 8) % 4;
      if (c < 2) begin
        exp_an   = 4'hF;
        exp_cath = 8'hFF;
      end else begin
        exp_an   = ~(4'b0001 << dg);
        exp_cath = ~d[8*dg +: 8];
      end
      exp_frame = (k > 0) && (k % 32 == 0);
      vectors++;
      if (an !== exp_an || cath !== exp_cath) begin
        miscompares++;
        $display("FAIL %s k=%0d an/cath: got %h/%h expected %h/%h", tag, k, an, cath, exp_an, exp_cath);
      end
      vectors++;
      if (frame !== exp_frame || pending !== exp_pend) begin
        miscompares++;
        $display("FAIL %s k=%0d frame/pending: got %b/%b expected %b/%b", tag, k, frame, pending, exp_frame, exp_pend);
      end
      step();
    end while (k % 32 != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; seg_in = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (an !== 4'hF || cath !== 8'hFF || frame !== 1'b0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got an=%h cath=%h frame=%b pending=%b expected F/FF/0/0", an, cath, frame, pending);
    end
    rst = 1'b0;
    k = 0;
    test_scan_frame(32'h0, 1'b0, "first_frame_zeros");
  endtask

  task automatic test_load();
    go_to(37);
    seg_in = 32'h3F06_5B4F; load = 1'b1;
    step();
    load = 1'b0;
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL load_pending: got %b expected 1", pending);
    end
    test_scan_frame(32'h0, 1'b1, "pre_boundary");
    vectors++;
    if (frame !== 1'b1 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_pulse: got frame=%b pending=%b expected 1/0", frame, pending);
    end
    go_to(66);
    vectors++;
    if (an !== 4'hE || cath !== 8'hB0) begin
      miscompares++;
      $display("FAIL slot0_pattern: got %h/%h expected E/B0", an, cath);
    end
    go_to(90);
    vectors++;
    if (an !== 4'h7 || cath !== 8'hC0) begin
      miscompares++;
      $display("FAIL slot3_pattern: got %h/%h expected 7/C0", an, cath);
    end
    test_scan_frame(32'h3F06_5B4F, 1'b0, "loaded_frame");
  endtask

  task automatic test_tear();
    go_to(105);
    seg_in = 32'h7F07_7D6D; load = 1'b1;
    step();
    load = 1'b0;
    test_scan_frame(32'h3F06_5B4F, 1'b1, "tear_old_persists");
    test_scan_frame(32'h7F07_7D6D, 1'b0, "tear_new_frame");
  endtask

  task automatic test_double_load();
    go_to(165);
    seg_in = 32'h0000_0006; load = 1'b1;
    step();
    load = 1'b0;
    go_to(175);
    seg_in = 32'h0000_005B; load = 1'b1;
    step();
    load = 1'b0;
    test_scan_frame(32'h7F07_7D6D, 1'b1, "double_load_wait");
    go_to(194);
    vectors++;
    if (an !== 4'hE || cath !== 8'hA4) begin
      miscompares++;
      $display("FAIL last_load_wins: got %h/%h expected E/A4", an, cath);
    end
    test_scan_frame(32'h0000_005B, 1'b0, "double_load_frame");
  endtask

  task automatic test_boundary_load();
    go_to(255);
    vectors++;
    if (pending !== 1'b0) begin
      miscompares++;
      $display("FAIL boundary_pre_pending: got %b expected 0", pending);
    end
    seg_in = 32'h0000_0066; load = 1'b1;
    step();
    load = 1'b0;
    go_to(258);
    vectors++;
    if (an !== 4'hE || cath !== 8'h99) begin
      miscompares++;
      $display("FAIL boundary_load_shown: got %h/%h expected E/99", an, cath);
    end
    test_scan_frame(32'h0000_0066, 1'b0, "boundary_load_frame");
  endtask

  task automatic test_reset_mid_slot();
    go_to(297);
    seg_in = 32'h1234_5678; load = 1'b1;
    step();
    load = 1'b0;
    go_to(299);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (an !== 4'hF || cath !== 8'hFF || frame !== 1'b0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got an=%h cath=%h frame=%b pending=%b expected F/FF/0/0", an, cath, frame, pending);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (an !== 4'hF || cath !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_hold: got %h/%h expected F/FF", an, cath);
    end
    rst = 1'b0;
    k = 0;
    test_scan_frame(32'h0, 1'b0, "restart_zeros");
    test_scan_frame(32'h0, 1'b0, "shadow_lost");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    k = 0;
    test_reset();
    test_load();
    test_tear();
    test_double_load();
    test_boundary_load();
    test_reset_mid_slot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
